if_fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC and runs a
//  req/ack handshake with variable-latency instruction memory. Presents {pc+4, instruction}
//  to IF/ID, or a NOP bubble when no word is ready. Honours the hazard-unit stall and

---
 rtl/if_fetch_stage_if.sv | 11 +
 rtl/if_fetch_stage.sv | 129 ++++++++++++
 tb/tb_if_fetch_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master; memory answers with ack/rdata, possibly in the req cycle.
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to variable-latency imem, and feeds IF/ID
// with {pc+4, instruction} or a bubble, honouring stall, redirect and wrong-path discard.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             pc_out,
  output logic [31:0]             inst_out,
  output logic                    inst_valid
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] hold_inst, hold_inst_n;
  logic [31:0] hold_pc, hold_pc_n;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign imem.addr    = req_addr;

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    hold_inst_n = hold_inst;
    hold_pc_n   = hold_pc;
    imem.req    = 1'b0;
    inst_out    = NOP_INST;
    pc_out      = 32'h0;
    inst_valid  = 1'b0;

    unique case (state)
      REQ: begin
        imem.req = 1'b1;
        if (redirect) begin
          pc_n = redirect_tgt;
          if (imem.ack) begin
            req_addr_n = redirect_tgt;
          end else begin
            // Keep the old address on the bus until memory answers, then throw it away.
            state_n = DROP;
          end
        end else if (imem.ack) begin
          inst_out   = imem.rdata;
          pc_out     = req_addr + 32'd4;
          inst_valid = 1'b1;
          if (stall) begin
            hold_inst_n = imem.rdata;
            hold_pc_n   = req_addr;
            state_n     = HOLD;
          end else begin
            pc_n       = req_addr + 32'd4;
            req_addr_n = req_addr + 32'd4;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_n       = redirect_tgt;
          req_addr_n = redirect_tgt;
          state_n    = REQ;
        end else begin
          inst_out   = hold_inst;
          pc_out     = hold_pc + 32'd4;
          inst_valid = 1'b1;
          if (!stall) begin
            pc_n       = hold_pc + 32'd4;
            req_addr_n = hold_pc + 32'd4;
            state_n    = REQ;
          end
        end
      end

      DROP: begin
        imem.req = 1'b1;
        if (redirect) pc_n = redirect_tgt;
        if (imem.ack) begin
          req_addr_n = redirect ? redirect_tgt : pc;
          state_n    = REQ;
        end
      end

      default: state_n = REQ;
    endcase

    // Reset masks the bus and IF/ID outputs regardless of state.
    if (rst) begin
      imem.req   = 1'b0;
      inst_out   = NOP_INST;
      pc_out     = 32'h0;
      inst_valid = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      req_addr  <= RESET_PC;
      hold_inst <= 32'h0;
      hold_pc   <= 32'h0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      req_addr  <= req_addr_n;
      hold_inst <= hold_inst_n;
      hold_pc   <= hold_pc_n;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a transaction-level model of the fetch
// stream: an outstanding address, a wrong-path flag and a queue of parked words.
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int          SEG_LEN  = 500;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;

  if_fetch_stage_if bus ();

  if_fetch_stage #(
    .RESET_PC (RESET_PC),
    .NOP_INST (NOP_INST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model of the fetch stream.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } parked_t;

  logic [31:0] m_next;     // address the program wants fetched next
  logic [31:0] m_out;      // address currently being requested
  bit          m_wrong;    // the in-flight response belongs to an abandoned path
  parked_t     m_park[$];  // word delivered under stall, waiting for IF/ID

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic model_reset();
    m_next  = RESET_PC;
    m_out   = RESET_PC;
    m_wrong = 1'b0;
    m_park.delete();
  endtask

  // Compare DUT outputs with what the model says this cycle should show.
  task automatic compare_outputs();
    logic        e_req, e_valid;
    logic [31:0] e_inst, e_pc;
    e_req   = 1'b0;
    e_valid = 1'b0;
    e_inst  = NOP_INST;
    e_pc    = 32'h0;
    if (!rst) begin
      if (m_park.size() != 0) begin
        if (!redirect) begin
          e_valid = 1'b1;
          e_inst  = m_park[0].inst;
          e_pc    = m_park[0].pc + 32'd4;
        end
      end else begin
        e_req = 1'b1;
        if (bus.ack && !redirect && !m_wrong) begin
          e_valid = 1'b1;
          e_inst  = bus.rdata;
          e_pc    = m_out + 32'd4;
        end
      end
    end
    check("imem_req", {31'b0, bus.req}, {31'b0, e_req});
    if (e_req) check("imem_addr", bus.addr, m_out);
    check("inst_valid", {31'b0, inst_valid}, {31'b0, e_valid});
    check("inst_out", inst_out, e_inst);
    check("pc_out", pc_out, e_pc);
  endtask

  // Advance the model across the coming clock edge.
  task automatic model_step();
    logic [31:0] tgt;
    parked_t     p;
    tgt = {redirect_pc[31:2], 2'b00};
    if (rst) begin
      model_reset();
    end else if (m_park.size() != 0) begin
      if (redirect) begin
        void'(m_park.pop_front());
        m_next = tgt;
        m_out  = tgt;
      end else if (!stall) begin
        p      = m_park.pop_front();
        m_next = p.pc + 32'd4;
        m_out  = m_next;
      end
    end else if (m_wrong) begin
      if (redirect) m_next = tgt;
      if (bus.ack) begin
        m_wrong = 1'b0;
        m_out   = m_next;
      end
    end else if (redirect) begin
      m_next = tgt;
      if (bus.ack) m_out = tgt;
      else         m_wrong = 1'b1;
    end else if (bus.ack) begin
      if (stall) begin
        p.inst = bus.rdata;
        p.pc   = m_out;
        m_park.push_back(p);
      end else begin
        m_out  = m_out + 32'd4;
        m_next = m_out;
      end
    end
  endtask

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0000_0100;
      2:       return 32'h0000_0200 | 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ack_pct, stall_pct, redir_pct, rst_pct;
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    bus.ack     = 1'b0;
    bus.rdata   = 32'h0;
    model_reset();

    for (int cyc = 0; cyc < 4 * SEG_LEN; cyc++) begin
      case (cyc / SEG_LEN)
        0:       begin ack_pct = 100; stall_pct = 0;  redir_pct = 0;  rst_pct = 0; end
        1:       begin ack_pct = 40;  stall_pct = 0;  redir_pct = 0;  rst_pct = 0; end
        2:       begin ack_pct = 60;  stall_pct = 35; redir_pct = 0;  rst_pct = 0; end
        default: begin ack_pct = 50;  stall_pct = 30; redir_pct = 15; rst_pct = 2; end
      endcase

      @(negedge clk);
      rst         = (cyc < 3) || ($urandom_range(0, 99) < rst_pct);
      stall       = $urandom_range(0, 99) < stall_pct;
      redirect    = $urandom_range(0, 99) < redir_pct;
      redirect_pc = redirect ? pick_target() : $urandom;
      // Memory only answers an outstanding request.
      bus.ack     = (!rst && m_park.size() == 0) && ($urandom_range(0, 99) < ack_pct);
      bus.rdata   = bus.ack ? mem_word(m_out) : $urandom;

      #1;
      compare_outputs();
      model_step();
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
